// File: rtl/mux_nx1_reg.sv
// rtl/mux_nx1_reg.sv - registered N-way selector with valid/ready handshake and two-entry skid buffer
// Optional feature macro: MUX_SEL_ERR_EN (sticky out-of-range select flag)
module mux_nx1_reg #(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SEL_W = 2
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [N*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]   sel,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SEL_W-1:0]   out_sel,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               sel_err
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_main_data;
  logic [WIDTH-1:0] r_skid_data;
  logic [SEL_W-1:0] r_main_sel;
  logic [SEL_W-1:0] r_skid_sel;
  logic [WIDTH-1:0] w_sel_data;
  logic             w_accept;
  logic             w_xfer;
  logic             w_load_main_in;
  logic             w_load_main_skid;
  logic             w_load_skid;

  // Handshake flags come from state only, so out_ready never reaches in_ready combinationally
  assign in_ready  = (r_state != S_TWO);
  assign out_valid = (r_state != S_EMPTY);
  assign w_accept  = in_valid && in_ready;
  assign w_xfer    = out_valid && out_ready;
  assign out_data  = r_main_data;
  assign out_sel   = r_main_sel;

  // Select the addressed channel; selects with no matching channel leave data at zero
  always_comb begin
    w_sel_data = '0;
    for (int k = 0; k < N; k++) begin
      if (sel == SEL_W'(k)) begin
        w_sel_data = in_bus[k*WIDTH +: WIDTH];
      end
    end
  end

  // Next state and register load enables for the main/skid pair
  always_comb begin
    w_state_nxt      = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    case (r_state)
      S_EMPTY: begin
        if (w_accept) begin
          w_state_nxt    = S_ONE;
          w_load_main_in = 1'b1;
        end
      end
      S_ONE: begin
        if (w_accept && w_xfer) begin
          w_load_main_in = 1'b1;
        end else if (w_accept) begin
          w_state_nxt = S_TWO;
          w_load_skid = 1'b1;
        end else if (w_xfer) begin
          w_state_nxt = S_EMPTY;
        end
      end
      S_TWO: begin
        if (w_xfer) begin
          w_state_nxt      = S_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_EMPTY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Main register drives the outputs; it keeps its last beat after draining
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_main_data <= '0;
      r_main_sel  <= '0;
    end else if (w_load_main_in) begin
      r_main_data <= w_sel_data;
      r_main_sel  <= sel;
    end else if (w_load_main_skid) begin
      r_main_data <= r_skid_data;
      r_main_sel  <= r_skid_sel;
    end
  end

  // Skid register catches the beat accepted while the consumer stalls
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_skid_data <= '0;
      r_skid_sel  <= '0;
    end else if (w_load_skid) begin
      r_skid_data <= w_sel_data;
      r_skid_sel  <= sel;
    end
  end

`ifdef MUX_SEL_ERR_EN
  logic w_sel_ok;
  logic r_sel_err;

  assign w_sel_ok = (int'(sel) < N);
  assign sel_err  = r_sel_err;

  // Sticky flag: set by any accepted beat whose select has no channel
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sel_err <= 1'b0;
    end else if (w_accept && !w_sel_ok) begin
      r_sel_err <= 1'b1;
    end
  end
`else
  assign sel_err = 1'b0;
`endif

endmodule

// File: tb/tb_mux_nx1_reg.sv
// tb/tb_mux_nx1_reg.sv - self-checking bench for mux_nx1_reg (N=4 and N=3 instances)
module tb_mux_nx1_reg;
  localparam int W = 32;
`ifdef MUX_SEL_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  typedef struct {
    logic [1:0]   sel;
    bit           v;
    bit           r;
    bit           e_ov;
    bit           e_ir;
    logic [W-1:0] e_d;
    logic [1:0]   e_s;
  } vec_t;

  typedef struct {
    logic [W-1:0] d;
    logic [1:0]   s;
  } beat_t;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [4*W-1:0] in_bus;
  logic [1:0]     sel;
  logic           in_valid;
  logic           out_ready;
  logic           ir4, ov4, err4, ir3, ov3, err3;
  logic [W-1:0]   od4, od3;
  logic [1:0]     os4, os3;

  logic [W-1:0]   ch [4];
  vec_t           tbl [10];
  beat_t          q [$];
  beat_t          last_b;
  beat_t          front;
  bit             exp_err;
  bit             prev_ir;
  bit             acc;
  bit             xfer;
  int             n_checks = 0;
  int             n_errors = 0;

  always #5 clk = ~clk;

  mux_nx1_reg #(.WIDTH(W), .N(4), .SEL_W(2)) u_dut4 (
    .clk(clk), .reset_n(reset_n), .in_bus(in_bus), .sel(sel),
    .in_valid(in_valid), .in_ready(ir4), .out_data(od4), .out_sel(os4),
    .out_valid(ov4), .out_ready(out_ready), .sel_err(err4)
  );

  mux_nx1_reg #(.WIDTH(W), .N(3), .SEL_W(2)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .in_bus(in_bus[3*W-1:0]), .sel(sel),
    .in_valid(in_valid), .in_ready(ir3), .out_data(od3), .out_sel(os3),
    .out_valid(ov3), .out_ready(out_ready), .sel_err(err3)
  );

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // The N=3 instance sees the same handshake; only sel==3 differs (zero data)
  task automatic check_all(input string name, input bit e_ov, input bit e_ir,
                           input logic [W-1:0] e_d, input logic [1:0] e_s, input bit e_err);
    logic [W-1:0] e_d3;
    e_d3 = (e_s == 2'd3) ? '0 : e_d;
    chk($sformatf("%s.ov4", name), W'(ov4), W'(e_ov));
    chk($sformatf("%s.ir4", name), W'(ir4), W'(e_ir));
    chk($sformatf("%s.od4", name), od4, e_d);
    chk($sformatf("%s.os4", name), W'(os4), W'(e_s));
    chk($sformatf("%s.err4", name), W'(err4), '0);
    chk($sformatf("%s.ov3", name), W'(ov3), W'(e_ov));
    chk($sformatf("%s.ir3", name), W'(ir3), W'(e_ir));
    chk($sformatf("%s.od3", name), od3, e_d3);
    chk($sformatf("%s.os3", name), W'(os3), W'(e_s));
    chk($sformatf("%s.err3", name), W'(err3), W'(e_err));
  endtask

  task automatic set_bus();
    in_bus = {ch[3], ch[2], ch[1], ch[0]};
  endtask

  task automatic load_fixed();
    ch[0] = 32'h11111111;
    ch[1] = 32'h22222222;
    ch[2] = 32'h33333333;
    ch[3] = 32'h44444444;
    set_bus();
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{2'd0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h11111111, 2'd0};
    tbl[1] = '{2'd1, 1'b1, 1'b1, 1'b1, 1'b1, 32'h22222222, 2'd1};
    tbl[2] = '{2'd2, 1'b1, 1'b1, 1'b1, 1'b1, 32'h33333333, 2'd2};
    tbl[3] = '{2'd3, 1'b1, 1'b1, 1'b1, 1'b1, 32'h44444444, 2'd3};
    tbl[4] = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h44444444, 2'd3};
    tbl[5] = '{2'd2, 1'b1, 1'b0, 1'b1, 1'b1, 32'h33333333, 2'd2};
    tbl[6] = '{2'd1, 1'b1, 1'b0, 1'b1, 1'b0, 32'h33333333, 2'd2};
    tbl[7] = '{2'd0, 1'b1, 1'b0, 1'b1, 1'b0, 32'h33333333, 2'd2};
    tbl[8] = '{2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h22222222, 2'd1};
    tbl[9] = '{2'd0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h22222222, 2'd1};

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    sel       = 2'd0;
    load_fixed();
    exp_err   = 1'b0;
    repeat (3) @(negedge clk);
    check_all("reset", 1'b0, 1'b1, '0, 2'd0, 1'b0);
    reset_n = 1'b1;

    // Streaming and backpressure vectors, starting at the first edge after release
    prev_ir = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid  = tbl[i].v;
      out_ready = tbl[i].r;
      sel       = tbl[i].sel;
      acc       = tbl[i].v && prev_ir;
      step();
      if (ERR_EN && acc && tbl[i].sel == 2'd3) exp_err = 1'b1;
      check_all($sformatf("tbl%0d", i), tbl[i].e_ov, tbl[i].e_ir, tbl[i].e_d, tbl[i].e_s, exp_err);
      prev_ir = tbl[i].e_ir;
    end

    // Accept and transfer every cycle: in_ready never drops
    for (int i = 0; i < 8; i++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      sel       = 2'(i);
      step();
      if (ERR_EN && sel == 2'd3) exp_err = 1'b1;
      check_all($sformatf("accx%0d", i), 1'b1, 1'b1, ch[i % 4], 2'(i), exp_err);
    end
    in_valid = 1'b0;
    step();
    check_all("accx_drain", 1'b0, 1'b1, ch[3], 2'd3, exp_err);

    // Random traffic against an occupancy-queue model
    q.delete();
    last_b = '{ch[3], 2'd3};
    for (int n = 0; n < 400; n++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      sel       = 2'($urandom_range(0, 3));
      for (int k = 0; k < 4; k++) ch[k] = $urandom;
      set_bus();
      xfer = (q.size() > 0) && out_ready;
      acc  = in_valid && (q.size() < 2);
      if (xfer) last_b = q.pop_front();
      if (acc) begin
        q.push_back('{ch[sel], sel});
        if (ERR_EN && sel == 2'd3) exp_err = 1'b1;
      end
      step();
      front = (q.size() > 0) ? q[0] : last_b;
      check_all("rand", q.size() > 0, q.size() < 2, front.d, front.s, exp_err);
    end

    // Fill to two beats, then reset asynchronously between edges
    load_fixed();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    step();
    step();
    in_valid  = 1'b1;
    out_ready = 1'b0;
    sel       = 2'd2;
    step();
    sel = 2'd1;
    step();
    chk("full_ir4", W'(ir4), '0);
    reset_n  = 1'b0;
    in_valid = 1'b0;
    #1;
    exp_err = 1'b0;
    check_all("async_rst", 1'b0, 1'b1, '0, 2'd0, 1'b0);
    @(negedge clk);
    reset_n   = 1'b1;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    sel       = 2'd1;
    step();
    check_all("post_rst", 1'b1, 1'b1, ch[1], 2'd1, 1'b0);
    in_valid = 1'b0;
    step();
    check_all("post_rst_alone", 1'b0, 1'b1, ch[1], 2'd1, 1'b0);

    // Out-of-range select on the N=3 instance
    in_valid = 1'b1;
    sel      = 2'd3;
    step();
    exp_err = ERR_EN;
    check_all("oor", 1'b1, 1'b1, ch[3], 2'd3, exp_err);
    sel = 2'd0;
    step();
    check_all("oor_keep", 1'b1, 1'b1, ch[0], 2'd0, exp_err);
    in_valid = 1'b0;
    step();
    check_all("oor_drain", 1'b0, 1'b1, ch[0], 2'd0, exp_err);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mux_nx1_reg.md
# mux_nx1_reg

Parametrised, registered N-way datapath selector with a valid/ready handshake and a two-entry skid buffer. It generalises the 2-input 32-bit operand mux used around the ALU to any width and channel count. It also adds an output register stage, so a select path can be retimed between the register file/ALU and its consumer without losing throughput under backpressure.

## Interface
- `WIDTH`, 32, data width of each channel and of the output.
- `N`, 4, number of input channels; legal range 2..16.
- `SEL_W`, 2, select width; constraint 2^SEL_W >= N.
- `clk` input 1: single clock; all state updates on the rising edge.
- `reset_n` input 1: reset, asynchronous, active-low.
- `in_bus` input N*WIDTH: channel k occupies bits [k*WIDTH +: WIDTH].
- `sel` input SEL_W: channel select, sampled with the input beat.
- `in_valid` input 1: an input beat is present.
- `in_ready` output 1: the block can accept a beat this cycle.
- `out_data` output WIDTH: registered selected data.
- `out_sel` output SEL_W: `sel` value that produced `out_data`.
- `out_valid` output 1: `out_data`/`out_sel` hold a beat.
- `out_ready` input 1: the consumer accepts the beat this cycle.
- `sel_err` output 1: sticky out-of-range-select flag (see Configuration).

## Operation
- Accept: `in_valid && in_ready` at a rising edge. Output transfer: `out_valid && out_ready` at a rising edge.
- Storage: a main register (drives outputs) and a skid register. Each holds {data, sel}.
- State machine:
  - EMPTY: accept -> ONE, main <= beat. No accept -> stay in EMPTY.
  - ONE: accept with transfer -> ONE, main <= new beat. Accept without transfer -> TWO, skid <= beat. Transfer without accept -> EMPTY. Neither -> hold.
  - TWO: no accept is possible. Transfer -> ONE, main <= skid. Otherwise hold.
- Outputs are decoded from state only:
  - `out_valid` = state != EMPTY.
  - `in_ready` = state != TWO.
  - There is no combinational path from `out_ready` to `in_ready`.
- Captured data is `in_bus[sel*WIDTH +: WIDTH]` when sel < N, else all-zero.
- Beats leave in acceptance order. None are dropped or duplicated.
- `out_data`/`out_sel` are stable while `out_valid && !out_ready`. After draining to EMPTY they keep their last value.
- Reset values while `reset_n` = 0:
  - state EMPTY, main and skid = 0.
  - `out_data` = 0, `out_sel` = 0, `out_valid` = 0, `in_ready` = 1, `sel_err` = 0.
- Reset asserted mid-operation discards all held beats immediately, without waiting for a clock edge.

## Timing
- Latency is 1 cycle: a beat accepted at edge t appears on `out_data` with `out_valid` = 1 after edge t.
- Throughput is 1 beat/cycle while `out_ready` = 1.
- Backpressure:
  - The first stalled accept fills the skid register; `in_ready` falls after that edge.
  - `in_ready` rises after the edge at which a transfer occurs in TWO.
- Reset release: the first accept is possible at the first rising edge with `reset_n` = 1.

## Configuration
- Macro `MUX_SEL_ERR_EN`.
- When defined:
  - An accepted beat with sel >= N still passes through with zero data and its `out_sel`.
  - `sel_err` goes to 1 after that edge and stays set until `reset_n` is asserted.
  - Simultaneous further errors have no additional effect.
- When undefined:
  - Out-of-range handling is zero data only.
  - `sel_err` is tied to constant 0 and no flag register is built.

## Test plan
- Reset: assert `reset_n` = 0 mid-stream in state TWO. Required: `out_valid` = 0, `in_ready` = 1, `out_data` = 0 immediately; after release the first new beat emerges alone.
- Streaming (N=4, WIDTH=32): channels loaded with 0x11111111..0x44444444, `out_ready` = 1, `sel` = 0,1,2,3 on consecutive cycles. Required: `out_data` sequence 0x11111111..0x44444444 one cycle later, no bubbles.
- Backpressure: `out_ready` = 0, present beats sel=2 then sel=1. Required: `in_ready` = 0 after the second accept; on `out_ready` = 1, the outputs are 0x33333333 then 0x22222222 and `in_ready` returns to 1.
- Simultaneous accept and transfer in ONE: with `in_valid` = `out_ready` = 1 held for 8 cycles, the state never leaves ONE and `in_ready` stays 1.
- Out-of-range select (N=3, SEL_W=2, sel=3):
  - `out_data` = 0, `out_sel` = 3.
  - `sel_err` = 1 from the next edge onward with `MUX_SEL_ERR_EN` defined, and stays 1 through later valid beats.
  - `sel_err` = 0 always without the macro.
